// File: rtl/video_start_sequencer.sv
// Restart sequencer for the HDMI output datapath: holds it in reset, loads the new video
// config, waits for buffered capture lines, triggers start and supervises fullcycle with retry.
module video_start_sequencer #(
  parameter int SETTLE_CYCLES  = 1024,
  parameter int START_LINES    = 4,
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       config_change,
  input  logic       in_frame_start,
  input  logic       in_line_done,
  input  logic       fullcycle,
  output logic       r2v_reset,
  output logic       config_load,
  output logic       starttrigger,
  output logic       running,
  output logic       failed,
  output logic [1:0] retry_count,
  output logic [3:0] seq_state
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int LW = $clog2(START_LINES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [LW-1:0] LINES_MAX  = LW'(START_LINES);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX  = 2'(MAX_RETRIES);

  typedef enum logic [3:0] {
    WAIT_LOCK  = 4'd0,
    HOLD       = 4'd1,
    LOAD       = 4'd2,
    WAIT_FRAME = 4'd3,
    FILL       = 4'd4,
    START      = 4'd5,
    WAIT_FULL  = 4'd6,
    RUN        = 4'd7,
    FAIL       = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [LW-1:0] line_q, line_d;
  logic [TW-1:0] to_q, to_d;
  logic [1:0]    retry_q, retry_d;
  logic [1:0]    retry_inc;
  logic          r2v_reset_q, r2v_reset_d;
  logic          config_load_q, config_load_d;
  logic          starttrigger_q, starttrigger_d;
  logic          running_q, running_d;
  logic          failed_q, failed_d;

  assign retry_inc = retry_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    line_d   = line_q;
    to_d     = to_q;
    retry_d  = retry_q;

    // settle_q counts HOLD cycles including the entry cycle, so entering HOLD loads 1
    case (state_q)
      WAIT_LOCK: begin
        if (pll_locked) begin
          state_d  = HOLD;
          settle_d = SW'(1);
        end
      end
      HOLD: begin
        if (settle_q >= SETTLE_MAX) state_d = LOAD;
        else                        settle_d = settle_q + SW'(1);
      end
      LOAD: state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (in_frame_start) begin
          state_d = FILL;
          line_d  = '0;
        end
      end
      FILL: begin
        if (in_frame_start) begin
          line_d = '0;
        end else if (in_line_done) begin
          line_d = line_q + LW'(1);
          if (line_q + LW'(1) >= LINES_MAX) begin
            state_d = START;
            to_d    = '0;
          end
        end
      end
      START: begin
        // to_q tracks cycles since starttrigger (START cycle = 0)
        state_d = WAIT_FULL;
        to_d    = TW'(1);
      end
      WAIT_FULL: begin
        if (fullcycle) begin
          state_d = RUN;
        end else if (to_q >= TO_LAST) begin
          retry_d = retry_inc;
          if (retry_inc < RETRY_MAX) begin
            state_d  = HOLD;
            settle_d = SW'(1);
          end else begin
            state_d = FAIL;
          end
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      RUN:     state_d = RUN;
      FAIL:    state_d = FAIL;
      default: state_d = WAIT_LOCK;
    endcase

    if (!pll_locked) begin
      state_d  = WAIT_LOCK;
      retry_d  = '0;
      settle_d = '0;
    end else if (config_change && state_q != WAIT_LOCK) begin
      state_d  = HOLD;
      retry_d  = '0;
      settle_d = SW'(1);
    end

    r2v_reset_d    = (state_d == WAIT_LOCK) || (state_d == HOLD) || (state_d == FAIL);
    config_load_d  = (state_d == LOAD);
    starttrigger_d = (state_d == START);
    running_d      = (state_d == RUN);
    failed_d       = (state_d == FAIL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT_LOCK;
      settle_q       <= '0;
      line_q         <= '0;
      to_q           <= '0;
      retry_q        <= '0;
      r2v_reset_q    <= 1'b1;
      config_load_q  <= 1'b0;
      starttrigger_q <= 1'b0;
      running_q      <= 1'b0;
      failed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      line_q         <= line_d;
      to_q           <= to_d;
      retry_q        <= retry_d;
      r2v_reset_q    <= r2v_reset_d;
      config_load_q  <= config_load_d;
      starttrigger_q <= starttrigger_d;
      running_q      <= running_d;
      failed_q       <= failed_d;
    end
  end

  assign r2v_reset    = r2v_reset_q;
  assign config_load  = config_load_q;
  assign starttrigger = starttrigger_q;
  assign running      = running_q;
  assign failed       = failed_q;
  assign retry_count  = retry_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_video_start_sequencer.sv
// Directed bench for video_start_sequencer with short settle/timeout parameters.
module tb_video_start_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       pll_locked, config_change, in_frame_start, in_line_done, fullcycle;
  logic       r2v_reset, config_load, starttrigger, running, failed;
  logic [1:0] retry_count;
  logic [3:0] seq_state;

  int n_tests = 0;
  int n_fail  = 0;

  video_start_sequencer #(
    .SETTLE_CYCLES(8), .START_LINES(2), .TIMEOUT_CYCLES(100), .MAX_RETRIES(2)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked), .config_change(config_change),
    .in_frame_start(in_frame_start), .in_line_done(in_line_done), .fullcycle(fullcycle),
    .r2v_reset(r2v_reset), .config_load(config_load), .starttrigger(starttrigger),
    .running(running), .failed(failed), .retry_count(retry_count), .seq_state(seq_state)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_line();
    in_line_done = 1'b1; tick(); in_line_done = 1'b0;
  endtask

  task automatic pulse_frame();
    in_frame_start = 1'b1; tick(); in_frame_start = 1'b0;
  endtask

  // From WAIT_LOCK with lock dropped: lock, settle, load, one frame + 2 lines -> sits in START
  task automatic bring_to_start();
    pll_locked = 1'b1;
    tick(10);
    pulse_frame();
    pulse_line();
    pulse_line();
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b0; config_change = 1'b0;
    in_frame_start = 1'b0; in_line_done = 1'b0; fullcycle = 1'b0;
    tick(2);
    n_tests++;
    if (seq_state !== 4'd0 || r2v_reset !== 1'b1 || config_load !== 1'b0 || starttrigger !== 1'b0 ||
        running !== 1'b0 || failed !== 1'b0 || retry_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d r2v=%b cl=%b st=%b run=%b fail=%b rc=%0d, want 0 1 0 0 0 0 0",
               seq_state, r2v_reset, config_load, starttrigger, running, failed, retry_count);
    end
    reset = 1'b0; pll_locked = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_tests++;
      if (seq_state !== 4'd1 || r2v_reset !== 1'b1 || config_load !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: state=%0d r2v=%b cl=%b, want 1 1 0", i, seq_state, r2v_reset, config_load);
      end
    end
    tick();
    n_tests++;
    if (seq_state !== 4'd2 || r2v_reset !== 1'b0 || config_load !== 1'b1) begin
      n_fail++;
      $display("FAIL load_cycle9: state=%0d r2v=%b cl=%b, want 2 0 1", seq_state, r2v_reset, config_load);
    end
    tick();
    n_tests++;
    if (seq_state !== 4'd3 || config_load !== 1'b0 || r2v_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL after_load: state=%0d cl=%b r2v=%b, want 3 0 0", seq_state, config_load, r2v_reset);
    end
  endtask

  task automatic test_frame_fill();
    for (int i = 0; i < 3; i++) pulse_line();
    n_tests++;
    if (seq_state !== 4'd3 || starttrigger !== 1'b0) begin
      n_fail++;
      $display("FAIL lines_before_frame: state=%0d st=%b, want 3 0", seq_state, starttrigger);
    end
    pulse_frame();
    pulse_line();
    n_tests++;
    if (seq_state !== 4'd4 || starttrigger !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_one_line: state=%0d st=%b, want 4 0", seq_state, starttrigger);
    end
    pulse_line();
    n_tests++;
    if (seq_state !== 4'd5 || starttrigger !== 1'b1 || r2v_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL start_pulse: state=%0d st=%b r2v=%b, want 5 1 0", seq_state, starttrigger, r2v_reset);
    end
    tick();
    n_tests++;
    if (seq_state !== 4'd6 || starttrigger !== 1'b0) begin
      n_fail++;
      $display("FAIL start_one_cycle: state=%0d st=%b, want 6 0", seq_state, starttrigger);
    end
  endtask

  // Entered at start+1; fullcycle asserted at start+50
  task automatic test_fullcycle();
    tick(49);
    n_tests++;
    if (seq_state !== 4'd6 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_full_50: state=%0d run=%b, want 6 0", seq_state, running);
    end
    fullcycle = 1'b1;
    tick();
    n_tests++;
    if (seq_state !== 4'd7 || running !== 1'b1 || retry_count !== 2'd0) begin
      n_fail++;
      $display("FAIL run_entry: state=%0d run=%b rc=%0d, want 7 1 0", seq_state, running, retry_count);
    end
    fullcycle = 1'b0;
    tick(5);
    n_tests++;
    if (seq_state !== 4'd7 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL run_latched: state=%0d run=%b, want 7 1", seq_state, running);
    end
  endtask

  task automatic test_lock_wins();
    config_change = 1'b1; pll_locked = 1'b0;
    tick();
    config_change = 1'b0;
    n_tests++;
    if (seq_state !== 4'd0 || running !== 1'b0 || retry_count !== 2'd0 || r2v_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_over_change: state=%0d run=%b rc=%0d r2v=%b, want 0 0 0 1",
               seq_state, running, retry_count, r2v_reset);
    end
  endtask

  task automatic test_timeout();
    bring_to_start();
    tick(99);
    n_tests++;
    if (seq_state !== 4'd6 || retry_count !== 2'd0) begin
      n_fail++;
      $display("FAIL before_timeout: state=%0d rc=%0d, want 6 0", seq_state, retry_count);
    end
    tick();
    n_tests++;
    if (seq_state !== 4'd1 || retry_count !== 2'd1 || r2v_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL first_timeout: state=%0d rc=%0d r2v=%b, want 1 1 1", seq_state, retry_count, r2v_reset);
    end
    tick(8);
    n_tests++;
    if (seq_state !== 4'd2 || config_load !== 1'b1) begin
      n_fail++;
      $display("FAIL retry_load: state=%0d cl=%b, want 2 1", seq_state, config_load);
    end
    tick();
    pulse_frame();
    pulse_line();
    pulse_line();
    tick(100);
    n_tests++;
    if (seq_state !== 4'd8 || failed !== 1'b1 || r2v_reset !== 1'b1 || retry_count !== 2'd2) begin
      n_fail++;
      $display("FAIL second_timeout: state=%0d fail=%b r2v=%b rc=%0d, want 8 1 1 2",
               seq_state, failed, r2v_reset, retry_count);
    end
    tick(20);
    n_tests++;
    if (seq_state !== 4'd8 || failed !== 1'b1) begin
      n_fail++;
      $display("FAIL fail_sticky: state=%0d fail=%b, want 8 1", seq_state, failed);
    end
    config_change = 1'b1;
    tick();
    config_change = 1'b0;
    n_tests++;
    if (seq_state !== 4'd1 || failed !== 1'b0 || retry_count !== 2'd0) begin
      n_fail++;
      $display("FAIL leave_fail: state=%0d fail=%b rc=%0d, want 1 0 0", seq_state, failed, retry_count);
    end
  endtask

  // Entered in HOLD at count 1
  task automatic test_change_in_hold();
    tick(4);
    config_change = 1'b1;
    tick();
    config_change = 1'b0;
    tick(7);
    n_tests++;
    if (seq_state !== 4'd1 || r2v_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_restart: state=%0d r2v=%b, want 1 1", seq_state, r2v_reset);
    end
    tick();
    n_tests++;
    if (seq_state !== 4'd2) begin
      n_fail++;
      $display("FAIL hold_restart_load: state=%0d, want 2", seq_state);
    end
    tick();
    pulse_frame();
    pulse_line();
    in_frame_start = 1'b1; in_line_done = 1'b1;
    tick();
    in_frame_start = 1'b0; in_line_done = 1'b0;
    pulse_line();
    n_tests++;
    if (seq_state !== 4'd4 || starttrigger !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_wins: state=%0d st=%b, want 4 0", seq_state, starttrigger);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (seq_state !== 4'd0 || r2v_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d r2v=%b, want 0 1", seq_state, r2v_reset);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_fill();
    test_fullcycle();
    test_lock_wins();
    test_timeout();
    test_change_in_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
